// File: rtl/iter_divider.sv
// Iterative 32-bit integer divider for DIV/DIVU/REM/REMU.
// One restoring radix-2 step per cycle; divide-by-zero and signed overflow resolve at accept.
module iter_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_valid,
  input  logic [1:0]  div_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        busy,
  output logic        div_done,
  output logic [31:0] div_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] out_q, out_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic        signed_op;
  logic [31:0] a_abs, b_abs;
  logic        div_by_zero, overflow;
  logic [31:0] special_res;
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_step, quo_step;
  logic [31:0] q_res, r_res, calc_res;

  // Even opcodes (DIV, REM) are the signed variants.
  assign signed_op   = ~div_op[0];
  assign a_abs       = (signed_op && dividend[31]) ? (~dividend + 32'd1) : dividend;
  assign b_abs       = (signed_op && divisor[31])  ? (~divisor + 32'd1)  : divisor;
  assign div_by_zero = (divisor == 32'd0);
  assign overflow    = signed_op && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
  assign special_res = div_by_zero ? (div_op[1] ? dividend : 32'hFFFF_FFFF)
                                   : (div_op[1] ? 32'd0 : 32'h8000_0000);

  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvsr_q};
    if (!diff[32]) begin
      rem_step = diff[31:0];
      quo_step = {quo_q[30:0], 1'b1};
    end else begin
      rem_step = rem_sh[31:0];
      quo_step = {quo_q[30:0], 1'b0};
    end
    q_res    = qneg_q ? (~quo_step + 32'd1) : quo_step;
    r_res    = rneg_q ? (~rem_step + 32'd1) : rem_step;
    calc_res = op_q[1] ? r_res : q_res;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_valid) begin
            op_d = div_op;
            if (div_by_zero || overflow) begin
              out_d   = special_res;
              state_d = DONE;
            end else begin
              rem_d   = 32'd0;
              quo_d   = a_abs;
              dvsr_d  = b_abs;
              qneg_d  = signed_op && (dividend[31] ^ divisor[31]);
              rneg_d  = signed_op && dividend[31];
              cnt_d   = 5'd0;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 5'd1;
          // The 32nd step's result feeds the output directly.
          if (cnt_q == 5'd31) begin
            out_d   = calc_res;
            cnt_d   = 5'd0;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvsr_q  <= 32'd0;
      out_q   <= 32'd0;
      cnt_q   <= 5'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign div_done = (state_q == DONE);
  assign div_out  = out_q;

endmodule
